beta_fetch: RTL

BETA_FETCH -- requirements
Module: beta_fetch

---
 rtl/beta_pkg.sv | 27 ++
 rtl/beta_pc_next.sv | 46 ++++
 rtl/beta_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// Shared definitions for the Beta instruction-fetch stage: PC-select codes,
// default vectors, fetch FSM states and the supervisor-preserving PC increment.
package beta_pkg;

    typedef enum logic [2:0] {
        PCSEL_INC   = 3'd0,
        PCSEL_BR    = 3'd1,
        PCSEL_JMP   = 3'd2,
        PCSEL_ILLOP = 3'd3,
        PCSEL_XADR  = 3'd4
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_XADR_VEC  = 32'h8000_0008;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_e;

    // Bit 31 is the supervisor flag; only the address bits below it advance.
    function automatic logic [31:0] beta_plus4(input logic [31:0] pc);
        beta_plus4 = {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/beta_pc_next.sv
// Combinational next-PC selection for the Beta fetch stage, including the
// user-mode interrupt override and the JMP supervisor-bit clamp.
module beta_pc_next
    import beta_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = DEFAULT_ILLOP_VEC,
    parameter logic [31:0] XADR_VEC  = DEFAULT_XADR_VEC
) (
    input  logic [31:0] pc,
    input  logic [15:0] lit,
    input  logic [31:0] ra_data,
    input  logic [2:0]  pc_sel,
    input  logic        irq,
    output logic [31:0] next_pc
);

    logic [31:0] pc_inc;
    logic [30:0] br_offset;
    logic [30:0] br_sum;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] sel_target;

    assign pc_inc    = beta_plus4(pc);
    assign br_offset = {{13{lit[15]}}, lit, 2'b00};
    assign br_sum    = pc_inc[30:0] + br_offset;
    assign br_target = {pc[31], br_sum};

    // A jump may drop out of supervisor mode but never enter it.
    assign jmp_target = {ra_data[31] & pc[31], ra_data[30:0]} & 32'hFFFF_FFFC;

    always_comb begin
        sel_target = ILLOP_VEC;
        case (pc_sel)
            PCSEL_INC:  sel_target = pc_inc;
            PCSEL_BR:   sel_target = br_target;
            PCSEL_JMP:  sel_target = jmp_target;
            PCSEL_XADR: sel_target = XADR_VEC;
            default:    sel_target = ILLOP_VEC;
        endcase
    end

    assign next_pc = (irq && !pc[31]) ? (XADR_VEC & 32'hFFFF_FFFC)
                                      : (sel_target & 32'hFFFF_FFFC);

endmodule

// File: rtl/beta_fetch.sv
// Beta instruction fetch: two-state REQ/HOLD handshake between instruction
// memory and the execute stage, owning the PC and instruction register.
module beta_fetch
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] ILLOP_VEC = DEFAULT_ILLOP_VEC,
    parameter logic [31:0] XADR_VEC  = DEFAULT_XADR_VEC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] ra_data,
    input  logic        irq,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  ir_reg, ir_next;
    logic [31:0]  target_pc;

    beta_pc_next #(
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_pc_next (
        .pc      (pc_reg),
        .lit     (ir_reg[15:0]),
        .ra_data (ra_data),
        .pc_sel  (pc_sel),
        .irq     (irq),
        .next_pc (target_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH_REQ;
            pc_reg    <= RESET_VEC & 32'hFFFF_FFFC;
            ir_reg    <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // ack in HOLD and ir_ready in REQ fall through to the defaults.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            FETCH_REQ: begin
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (ir_ready) begin
                    pc_next    = target_pc;
                    state_next = FETCH_REQ;
                end
            end
            default: state_next = FETCH_REQ;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    assign imem_req  = (state_reg == FETCH_REQ) && !reset;
    assign ir_valid  = (state_reg == FETCH_HOLD) && !reset;
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign pc_plus4  = beta_plus4(pc_reg);
    assign ir        = ir_reg;
    assign opcode    = ir_reg[31:26];

endmodule
